// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared branch-predictor types, default widths and the gshare
//                index helper used by gshare_predictor_ckpt.
//  Revision    : 1.0 - initial parametrised gshare release
// ============================================================================
package bp_pkg;

    // Default configuration widths
    localparam int BP_XLEN     = 32;
    localparam int BP_GHR_BITS = 10;
    localparam int BP_IDX_BITS = 8;

    // Widest operands bp_index accepts; callers zero-extend into these
    localparam int BP_PC_MAX   = 64;
    localparam int BP_GHR_MAX  = 32;
    localparam int BP_IDX_MAX  = 16;

    // Resolve packet from the execute/retire branch path (default widths)
    typedef struct packed {
        logic                   valid;
        logic [BP_XLEN-1:0]     pc;
        logic [BP_GHR_BITS-1:0] ghist;
        logic                   taken;
        logic                   mispredict;
    } BP_RESOLVE_PACKET;

    // Speculative-history packet from ID
    typedef struct packed {
        logic valid;
        logic taken;
    } BP_SPEC_PACKET;

    // gshare index: pc[idx_bits+1:2] XOR folded history. History bits beyond
    // the supplied history width arrive as zeros, which gives the
    // zero-extension for short histories; bits above idx_bits are dropped.
    function automatic logic [BP_IDX_MAX-1:0] bp_index(
        input logic [BP_PC_MAX-1:0]  pc,
        input logic [BP_GHR_MAX-1:0] hist,
        input int                    idx_bits
    );
        logic [BP_IDX_MAX-1:0] r;
        r = '0;
        for (int b = 0; b < BP_IDX_MAX; b++) begin
            if (b < idx_bits) begin
                r[b] = pc[b+2] ^ hist[b];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter_update.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter_update
//  Description : Combinational saturating up/down counter step.
//  Revision    : 1.0 - initial release
//  Ports       : ctr_i   - current counter value
//                taken_i - 1 increments, 0 decrements
//                next_o  - updated value, saturating at 0 and all-ones
// ============================================================================
module sat_counter_update #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr_i,
    input  logic                taken_i,
    output logic [CTR_BITS-1:0] next_o
);

    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};

    always_comb begin
        next_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_MAX) begin
                next_o = ctr_i + 1'b1;
            end
        end else if (ctr_i != '0) begin
            next_o = ctr_i - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gshare_predictor_ckpt.sv
`default_nettype none
// ============================================================================
//  Module      : gshare_predictor_ckpt
//  Description : N-lane gshare direction predictor with lane-ordered
//                speculative history, per-lane history checkpoints and a
//                multi-cycle table-initialisation sweep.
//  Revision    : 1.0 - initial release
//  Ports       : clock / reset          - clock, synchronous active-high reset
//                ready_o                - table initialised
//                lookup_pc_i            - fetch-group PCs, lane 0 oldest
//                pred_taken_o           - predicted direction per lane
//                pred_ghist_o           - history used per lane (checkpoint)
//                spec_valid_i/taken_i   - speculative history updates per lane
//                resolve_*_i            - resolved branches (train + recover)
// ============================================================================
module gshare_predictor_ckpt
    import bp_pkg::*;
#(
    parameter int N              = 3,
    parameter int XLEN           = BP_XLEN,
    parameter int GHR_BITS       = BP_GHR_BITS,
    parameter int IDX_BITS       = BP_IDX_BITS,
    parameter int CTR_BITS       = 2,
    parameter int INIT_CTR       = 2**(CTR_BITS-1),
    parameter int INIT_PER_CYCLE = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  ready_o,
    input  logic [N*XLEN-1:0]     lookup_pc_i,
    output logic [N-1:0]          pred_taken_o,
    output logic [N*GHR_BITS-1:0] pred_ghist_o,
    input  logic [N-1:0]          spec_valid_i,
    input  logic [N-1:0]          spec_taken_i,
    input  logic [N-1:0]          resolve_valid_i,
    input  logic [N*XLEN-1:0]     resolve_pc_i,
    input  logic [N*GHR_BITS-1:0] resolve_ghist_i,
    input  logic [N-1:0]          resolve_taken_i,
    input  logic [N-1:0]          resolve_mispredict_i
);

    localparam int                  DEPTH      = 2**IDX_BITS;
    localparam logic [CTR_BITS-1:0] INIT_VAL   = CTR_BITS'(INIT_CTR);
    localparam logic [IDX_BITS-1:0] PTR_STEP   = IDX_BITS'(INIT_PER_CYCLE);
    localparam logic [IDX_BITS-1:0] LAST_GROUP = IDX_BITS'(DEPTH - INIT_PER_CYCLE);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] init_ptr_q, init_ptr_d;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [CTR_BITS-1:0] table_q [DEPTH];

    logic [GHR_BITS-1:0] hist      [N+1];
    logic [IDX_BITS-1:0] lk_idx    [N];
    logic [IDX_BITS-1:0] res_idx   [N];
    logic [CTR_BITS-1:0] lane_next [N];
    logic                mp_any;
    logic [GHR_BITS-1:0] mp_hist;

    assign ready_o = (state_q == ST_READY);

    // Lane-ordered speculative history; spec bits are ignored until ready
    always_comb begin
        hist[0] = ghr_q;
        for (int i = 0; i < N; i++) begin
            hist[i+1] = hist[i];
            if (ready_o && spec_valid_i[i]) begin
                hist[i+1] = {hist[i][GHR_BITS-2:0], spec_taken_i[i]};
            end
        end
    end

    always_comb begin
        pred_taken_o = '0;
        pred_ghist_o = '0;
        for (int i = 0; i < N; i++) begin
            lk_idx[i]  = IDX_BITS'(bp_index(64'(lookup_pc_i[i*XLEN +: XLEN]),
                                            32'(hist[i]), IDX_BITS));
            res_idx[i] = IDX_BITS'(bp_index(64'(resolve_pc_i[i*XLEN +: XLEN]),
                                            32'(resolve_ghist_i[i*GHR_BITS +: GHR_BITS]),
                                            IDX_BITS));
            pred_taken_o[i] = ready_o & table_q[lk_idx[i]][CTR_BITS-1];
            pred_ghist_o[i*GHR_BITS +: GHR_BITS] = hist[i];
        end
    end

    // Training chain: each lane starts from the table value, or from the
    // result of the youngest older lane hitting the same entry this cycle.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [CTR_BITS-1:0] src [i+1];
        logic [CTR_BITS-1:0] ctr_in;
        logic [CTR_BITS-1:0] ctr_next;

        assign src[0] = table_q[res_idx[i]];
        for (genvar j = 0; j < i; j++) begin : g_fwd
            assign src[j+1] = g_lane[j].ctr_next;
        end

        always_comb begin
            ctr_in = src[0];
            for (int j = 0; j < i; j++) begin
                if (resolve_valid_i[j] && (res_idx[j] == res_idx[i])) begin
                    ctr_in = src[j+1];
                end
            end
        end

        sat_counter_update #(
            .CTR_BITS (CTR_BITS)
        ) u_ctr (
            .ctr_i   (ctr_in),
            .taken_i (resolve_taken_i[i]),
            .next_o  (ctr_next)
        );

        assign lane_next[i] = ctr_next;
    end

    // Recovery history from the lowest mispredicting lane
    always_comb begin
        mp_any  = 1'b0;
        mp_hist = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (resolve_valid_i[i] && resolve_mispredict_i[i]) begin
                mp_any  = 1'b1;
                mp_hist = {resolve_ghist_i[i*GHR_BITS +: GHR_BITS-1], resolve_taken_i[i]};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        ghr_d      = ghr_q;
        case (state_q)
            ST_INIT: begin
                ghr_d      = '0;
                init_ptr_d = init_ptr_q + PTR_STEP;
                if (init_ptr_q == LAST_GROUP) begin
                    state_d    = ST_READY;
                    init_ptr_d = '0;
                end
            end
            ST_READY: begin
                ghr_d = mp_any ? mp_hist : hist[N];
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            ghr_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            ghr_q      <= ghr_d;
        end
    end

    // Table has no reset: it is swept group by group while in INIT. Same-index
    // lanes write in lane order, so the youngest (accumulated) value lands.
    always_ff @(posedge clock) begin
        if (state_q == ST_INIT) begin
            for (int k = 0; k < INIT_PER_CYCLE; k++) begin
                table_q[init_ptr_q + IDX_BITS'(k)] <= INIT_VAL;
            end
        end else if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (resolve_valid_i[i]) begin
                    table_q[res_idx[i]] <= lane_next[i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gshare_predictor_ckpt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_gshare_predictor_ckpt
//  Description : Self-checking bench for gshare_predictor_ckpt against an
//                arithmetic reference model (table array, integer GHR).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gshare_predictor_ckpt;
    import bp_pkg::*;

    localparam int N           = 3;
    localparam int XLEN        = 32;
    localparam int GHR_BITS    = 10;
    localparam int IDX_BITS    = 8;
    localparam int CTR_BITS    = 2;
    localparam int INIT_PER    = 4;
    localparam int DEPTH       = 256;
    localparam int INIT_CYCLES = DEPTH / INIT_PER;
    localparam int INIT_CTR    = 2;
    localparam int CTR_MAX     = 3;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  ready_o;
    logic [N*XLEN-1:0]     lookup_pc;
    logic [N-1:0]          pred_taken;
    logic [N*GHR_BITS-1:0] pred_ghist;
    logic [N-1:0]          spec_valid, spec_taken;
    logic [N-1:0]          res_valid, res_taken, res_mp;
    logic [N*XLEN-1:0]     res_pc;
    logic [N*GHR_BITS-1:0] res_ghist;

    logic [XLEN-1:0]  lk_pc    [N];
    BP_SPEC_PACKET    spec_pkt [N];
    BP_RESOLVE_PACKET res_pkt  [N];

    int n_checks = 0;
    int n_fail   = 0;

    int m_tbl [DEPTH];
    int m_ghr = 0;
    bit m_ready = 1'b0;
    int m_init_cnt = 0;

    always #5 clock = ~clock;

    always_comb begin
        lookup_pc = '0; spec_valid = '0; spec_taken = '0;
        res_valid = '0; res_taken = '0; res_mp = '0; res_pc = '0; res_ghist = '0;
        for (int i = 0; i < N; i++) begin
            lookup_pc[i*XLEN +: XLEN]         = lk_pc[i];
            spec_valid[i]                     = spec_pkt[i].valid;
            spec_taken[i]                     = spec_pkt[i].taken;
            res_valid[i]                      = res_pkt[i].valid;
            res_pc[i*XLEN +: XLEN]            = res_pkt[i].pc;
            res_ghist[i*GHR_BITS +: GHR_BITS] = res_pkt[i].ghist;
            res_taken[i]                      = res_pkt[i].taken;
            res_mp[i]                         = res_pkt[i].mispredict;
        end
    end

    gshare_predictor_ckpt #(
        .N(N), .XLEN(XLEN), .GHR_BITS(GHR_BITS), .IDX_BITS(IDX_BITS),
        .CTR_BITS(CTR_BITS), .INIT_CTR(INIT_CTR), .INIT_PER_CYCLE(INIT_PER)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .ready_o              (ready_o),
        .lookup_pc_i          (lookup_pc),
        .pred_taken_o         (pred_taken),
        .pred_ghist_o         (pred_ghist),
        .spec_valid_i         (spec_valid),
        .spec_taken_i         (spec_taken),
        .resolve_valid_i      (res_valid),
        .resolve_pc_i         (res_pc),
        .resolve_ghist_i      (res_ghist),
        .resolve_taken_i      (res_taken),
        .resolve_mispredict_i (res_mp)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int f_idx(input logic [31:0] pc, input int h);
        return int'(((pc >> 2) ^ 32'(h)) & 32'hFF);
    endfunction

    function automatic int f_push(input int h, input bit t);
        return ((h * 2) + int'(t)) % 1024;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            lk_pc[i] = '0;
            spec_pkt[i] = '0;
            res_pkt[i] = '0;
        end
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < N; i++) begin
            lk_pc[i]              = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2);
            spec_pkt[i].valid     = 1'($urandom_range(0, 1));
            spec_pkt[i].taken     = 1'($urandom_range(0, 1));
            res_pkt[i].valid      = 1'($urandom_range(0, 1));
            res_pkt[i].pc         = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2);
            res_pkt[i].ghist      = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
            res_pkt[i].taken      = 1'($urandom_range(0, 1));
            res_pkt[i].mispredict = ($urandom_range(0, 7) == 0);
        end
    endtask

    // Compare all outputs against the model, then advance one clock and
    // apply the same inputs to the model.
    task automatic step();
        int h;
        int idx;
        int v;
        bit mp;
        #1;
        h = m_ghr;
        for (int i = 0; i < N; i++) begin
            check_val($sformatf("ghist%0d", i), 32'(pred_ghist[i*GHR_BITS +: GHR_BITS]), 32'(h));
            idx = f_idx(lk_pc[i], h);
            check_val($sformatf("pred%0d", i), 32'(pred_taken[i]),
                      (m_ready && m_tbl[idx] >= 2) ? 32'd1 : 32'd0);
            if (m_ready && spec_pkt[i].valid) h = f_push(h, spec_pkt[i].taken);
        end
        check_val("ready", 32'(ready_o), 32'(m_ready));
        @(posedge clock);
        if (reset) begin
            m_ready = 1'b0; m_init_cnt = 0; m_ghr = 0;
        end else if (!m_ready) begin
            m_init_cnt++;
            if (m_init_cnt == INIT_CYCLES) begin
                m_ready = 1'b1;
                for (int e = 0; e < DEPTH; e++) m_tbl[e] = INIT_CTR;
            end
        end else begin
            mp = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (res_pkt[i].valid) begin
                    idx = f_idx(res_pkt[i].pc, int'(res_pkt[i].ghist));
                    v = m_tbl[idx] + (res_pkt[i].taken ? 1 : -1);
                    m_tbl[idx] = (v < 0) ? 0 : ((v > CTR_MAX) ? CTR_MAX : v);
                    if (res_pkt[i].mispredict && !mp) begin
                        mp = 1'b1;
                        m_ghr = f_push(int'(res_pkt[i].ghist), res_pkt[i].taken);
                    end
                end
            end
            if (!mp) m_ghr = h;
        end
        @(negedge clock);
    endtask

    // Run INIT with random traffic plus a not-taken resolve on pc 0x100 /
    // ghist 0 in lane 0; returns the number of cycles spent before ready.
    task automatic run_init(input int max_cycles, output int cycles);
        cycles = 0;
        while (cycles < max_cycles) begin
            rand_inputs();
            res_pkt[0] = '{valid: 1'b1, pc: 32'h100, ghist: '0, taken: 1'b0, mispredict: 1'b1};
            step();
            cycles++;
            if (ready_o) break;
        end
    endtask

    task automatic train_lanes(input bit t, input int lanes);
        clear_inputs();
        for (int i = 0; i < lanes; i++) begin
            res_pkt[i] = '{valid: 1'b1, pc: 32'h100, ghist: '0, taken: t, mispredict: 1'b0};
        end
        step();
    endtask

    task automatic probe_0x40(input string tag, input logic exp);
        clear_inputs();
        for (int i = 0; i < N; i++) lk_pc[i] = 32'h108;  // idx 0x40 with GHR = 2
        #1;
        check_val(tag, 32'(pred_taken[0]), 32'(exp));
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout sim time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        repeat (3) begin rand_inputs(); step(); end

        // Sweep interrupted by reset, then a full uninterrupted sweep
        reset = 1'b0;
        run_init(30, cyc);
        check_val("ready_mid_init", 32'(ready_o), 32'd0);
        reset = 1'b1;
        rand_inputs();
        step();
        reset = 1'b0;
        run_init(200, cyc);
        check_val("init_cycles", 32'(cyc), 32'(INIT_CYCLES));

        // First lookup after ready: entry 0x40 still holds INIT_CTR
        clear_inputs();
        for (int i = 0; i < N; i++) lk_pc[i] = 32'h100;
        #1;
        check_val("first_pred", 32'(pred_taken), 32'h7);
        step();

        // Lane-ordered history from GHR = 0
        clear_inputs();
        spec_pkt[0] = '{valid: 1'b1, taken: 1'b1};
        spec_pkt[1] = '{valid: 1'b1, taken: 1'b0};
        spec_pkt[2] = '{valid: 1'b0, taken: 1'b1};
        #1;
        check_val("lane_hist", 32'(pred_ghist), 32'({10'd2, 10'd1, 10'd0}));
        step();
        clear_inputs();
        #1;
        check_val("ghr_after_spec", 32'(pred_ghist[GHR_BITS-1:0]), 32'd2);

        // Same-index accumulation and saturation at both ends
        train_lanes(1'b1, 3);          // 2 -> 3 saturated
        probe_0x40("sat_hi", 1'b1);
        train_lanes(1'b0, 1);          // 3 -> 2
        probe_0x40("after_dec", 1'b1);
        train_lanes(1'b0, 2);          // 2 -> 0
        train_lanes(1'b0, 2);          // stays 0
        probe_0x40("sat_lo", 1'b0);
        train_lanes(1'b1, 1);          // 0 -> 1
        probe_0x40("from_zero", 1'b0);

        // Mispredict recovery: lowest mispredicting lane wins, spec dropped
        clear_inputs();
        for (int i = 0; i < N; i++) spec_pkt[i] = '{valid: 1'b1, taken: 1'b1};
        res_pkt[1] = '{valid: 1'b1, pc: 32'h40, ghist: 10'h155, taken: 1'b0, mispredict: 1'b1};
        res_pkt[2] = '{valid: 1'b1, pc: 32'h80, ghist: 10'h0F0, taken: 1'b1, mispredict: 1'b1};
        step();
        clear_inputs();
        #1;
        check_val("recover_ghr", 32'(pred_ghist[GHR_BITS-1:0]), 32'h2AA);

        // Randomised traffic
        repeat (400) begin rand_inputs(); step(); end

        // Reset from READY and re-initialise
        reset = 1'b1;
        rand_inputs();
        step();
        reset = 1'b0;
        run_init(200, cyc);
        check_val("reinit_cycles", 32'(cyc), 32'(INIT_CYCLES));
        repeat (100) begin rand_inputs(); step(); end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
